ps2_key_decoder: RTL and testbench

Converts the raw PS/2 byte stream from `ps2_recv` into clean game commands for the player weapon and monster-set logic. It tracks make/break/extended prefixes and keeps a held-key bitmap. It emits exactly one command pulse per physical key press, suppressing typematic repeats. Movement keys get an optional controlled auto-repeat. The block sits between `ps2_recv` and the `weapon` / `setOfMonster_data` command inputs, replacing the ad-hoc keyboard router.

---
 rtl/ps2_key_pkg.sv | 53 +++++
 rtl/ps2_key_decoder_timer.sv | 46 ++++
 rtl/ps2_key_decoder.sv | 183 ++++++++++++++++++
 tb/tb_ps2_key_decoder.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_key_pkg.sv
// ps2_key_pkg
// Shared definitions for the PS/2 keyboard command decoder:
//   - scan-code constants for the six game keys and the F0/E0 prefixes
//   - command bit indices used by cmd_pulse / cmd_held
//   - the parser state encoding
//   - keyToCmd(), which maps a scan code to its one-hot command mask
package ps2_key_pkg;

    // Set-2 scan codes for the game keys and the two prefix bytes
    localparam logic [7:0] SC_LEFT     = 8'h6B;
    localparam logic [7:0] SC_RIGHT    = 8'h74;
    localparam logic [7:0] SC_FORWARD  = 8'h73;
    localparam logic [7:0] SC_BACKWARD = 8'h75;
    localparam logic [7:0] SC_FIRE     = 8'h29;
    localparam logic [7:0] SC_RELOAD   = 8'h2D;
    localparam logic [7:0] SC_BREAK    = 8'hF0;
    localparam logic [7:0] SC_EXT      = 8'hE0;

    // Bit positions inside cmd_pulse / cmd_held
    localparam int CMD_LEFT     = 0;
    localparam int CMD_RIGHT    = 1;
    localparam int CMD_FORWARD  = 2;
    localparam int CMD_BACKWARD = 3;
    localparam int CMD_FIRE     = 4;
    localparam int CMD_RELOAD   = 5;
    localparam int CMD_COUNT    = 6;

    // Parser states: nothing pending, F0 seen, E0 seen, E0 F0 seen
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BRK     = 2'd1,
        ST_EXT     = 2'd2,
        ST_EXT_BRK = 2'd3
    } parseState_t;

    // One-hot command mask for a scan code; all zeros when the code is unmapped.
    // The E0 prefix is never part of the match, so arrow and keypad keys collide.
    function automatic logic [CMD_COUNT-1:0] keyToCmd(input logic [7:0] code);
        logic [CMD_COUNT-1:0] mask;
        mask = '0;
        case (code)
            SC_LEFT:     mask[CMD_LEFT]     = 1'b1;
            SC_RIGHT:    mask[CMD_RIGHT]    = 1'b1;
            SC_FORWARD:  mask[CMD_FORWARD]  = 1'b1;
            SC_BACKWARD: mask[CMD_BACKWARD] = 1'b1;
            SC_FIRE:     mask[CMD_FIRE]     = 1'b1;
            SC_RELOAD:   mask[CMD_RELOAD]   = 1'b1;
            default:     mask               = '0;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/ps2_key_decoder_timer.sv
// key_repeat_timer
// Loadable down-counter shared by the movement auto-repeat and the prefix
// timeout. After a load the counter holds RELOAD; each cycle with run high it
// steps down by one, and expire is raised in the cycle it steps from 1 to 0,
// i.e. exactly RELOAD run-cycles after the load. RELOAD = 0 never expires.
// Ports:
//   topIN_clk_50  in   clock
//   wire_reset    in   asynchronous active-high reset (count -> 0)
//   load          in   reload to RELOAD (highest priority)
//   clear         in   force the count to 0
//   run           in   count down this cycle
//   expire        out  combinational: run is high and the count is at 1
module key_repeat_timer #(
    parameter int unsigned RELOAD = 100
) (
    input  logic topIN_clk_50,
    input  logic wire_reset,
    input  logic load,
    input  logic clear,
    input  logic run,
    output logic expire
);

    localparam int W = (RELOAD > 1) ? $clog2(RELOAD + 1) : 1;
    localparam logic [W-1:0] LOAD_VALUE = W'(RELOAD);
    localparam logic [W-1:0] ONE        = W'(1);

    logic [W-1:0] count;

    // Load wins over clear so that a fresh load in the same cycle as an idle
    // clear still arms the counter; the count parks at 0 once it runs out.
    always_ff @(posedge topIN_clk_50 or posedge wire_reset) begin
        if (wire_reset) begin
            count <= '0;
        end else if (load) begin
            count <= LOAD_VALUE;
        end else if (clear) begin
            count <= '0;
        end else if (run && (count != '0)) begin
            count <= count - ONE;
        end
    end

    assign expire = run && (count == ONE);

endmodule

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder
// Turns the raw PS/2 byte stream into game commands: one pulse per physical
// key press (typematic repeats suppressed), a held-key bitmap, controlled
// auto-repeat for the four movement keys and a strobe for unmapped make codes.
// Ports:
//   topIN_clk_50     in   50 MHz system clock
//   wire_reset       in   asynchronous active-high reset
//   scan_code        in   byte from ps2_recv, valid with scan_code_ready
//   scan_code_ready  in   one-cycle strobe for a new byte
//   enable           in   game active; low forces the pulse outputs to 0
//   cmd_pulse        out  one-cycle command strobes (left,right,fwd,back,fire,reload)
//   cmd_held         out  per-command key-down level, same bit order
//   unknown_code     out  one-cycle strobe for an unmapped make code
//   last_code        out  most recent non-prefix byte
module ps2_key_decoder
    import ps2_key_pkg::*;
#(
    parameter int unsigned MOVE_REPEAT_CYCLES = 12_500_000,
    parameter int unsigned PREFIX_TIMEOUT     = 1_000_000
) (
    input  logic       topIN_clk_50,
    input  logic       wire_reset,
    input  logic [7:0] scan_code,
    input  logic       scan_code_ready,
    input  logic       enable,
    output logic [5:0] cmd_pulse,
    output logic [5:0] cmd_held,
    output logic       unknown_code,
    output logic [7:0] last_code
);

    parseState_t state;

    logic [5:0] cmdPulse;
    logic [5:0] cmdHeld;
    logic       unknownCode;
    logic [7:0] lastCode;

    logic       byteIsPrefix;
    logic       byteIsMake;
    logic       byteIsBreak;
    logic [5:0] keyMask;
    logic [5:0] heldNext;
    logic [5:0] makePulse;
    logic [5:0] repeatPulse;
    logic [5:0] pulseNext;
    logic       unknownNext;
    logic       anyMoveNext;

    logic       prefLoad;
    logic       prefClear;
    logic       prefRun;
    logic       prefExpire;
    logic       repLoad;
    logic       repClear;
    logic       repRun;
    logic       repExpire;

    // Classify the incoming byte against the current parser state and work out
    // what it does to the held bitmap. Everything downstream (repeat timer,
    // pulses) looks at heldNext so the byte is always applied before a repeat
    // expiry in the same cycle, and a key released by this byte never repeats.
    always_comb begin
        byteIsPrefix = 1'b0;
        byteIsMake   = 1'b0;
        byteIsBreak  = 1'b0;
        keyMask      = keyToCmd(scan_code);
        heldNext     = cmdHeld;
        makePulse    = '0;
        unknownNext  = 1'b0;

        if (scan_code_ready) begin
            if ((scan_code == SC_BREAK) || (scan_code == SC_EXT)) begin
                byteIsPrefix = 1'b1;
            end else if ((state == ST_BRK) || (state == ST_EXT_BRK)) begin
                byteIsBreak = 1'b1;
            end else begin
                byteIsMake = 1'b1;
            end
        end

        if (byteIsMake) begin
            heldNext    = cmdHeld | keyMask;
            makePulse   = keyMask & ~cmdHeld;
            unknownNext = enable && (keyMask == '0);
        end else if (byteIsBreak) begin
            heldNext = cmdHeld & ~keyMask;
        end
    end

    // The prefix timer is re-armed by every prefix byte and parked at 0 in IDLE;
    // a data byte arriving on the expiry cycle is handled by the FSM first.
    assign prefLoad  = byteIsPrefix;
    assign prefClear = (state == ST_IDLE);
    assign prefRun   = (state != ST_IDLE);

    key_repeat_timer #(
        .RELOAD(PREFIX_TIMEOUT)
    ) prefixTimer (
        .topIN_clk_50(topIN_clk_50),
        .wire_reset  (wire_reset),
        .load        (prefLoad),
        .clear       (prefClear),
        .run         (prefRun),
        .expire      (prefExpire)
    );

    // One shared repeat counter for the movement keys: idle at 0 with nothing
    // held, held at reload while the game is disabled, re-armed by any fresh
    // movement press and by its own expiry.
    assign anyMoveNext = |heldNext[CMD_BACKWARD:CMD_LEFT];
    assign repRun      = enable && anyMoveNext;
    assign repClear    = !anyMoveNext;
    assign repLoad     = anyMoveNext &&
                         (!enable || (|makePulse[CMD_BACKWARD:CMD_LEFT]) || repExpire);
    assign repeatPulse = repExpire ? {2'b00, heldNext[CMD_BACKWARD:CMD_LEFT]} : 6'b000000;
    assign pulseNext   = enable ? (makePulse | repeatPulse) : 6'b000000;

    key_repeat_timer #(
        .RELOAD(MOVE_REPEAT_CYCLES)
    ) repeatTimer (
        .topIN_clk_50(topIN_clk_50),
        .wire_reset  (wire_reset),
        .load        (repLoad),
        .clear       (repClear),
        .run         (repRun),
        .expire      (repExpire)
    );

    // Parser FSM plus all registered outputs. A prefix byte seen while already
    // inside a prefix state keeps that state, except that F0 after E0 moves on
    // to EXT_BRK. With no byte, an expired prefix timer drops back to IDLE.
    always_ff @(posedge topIN_clk_50 or posedge wire_reset) begin
        if (wire_reset) begin
            state       <= ST_IDLE;
            cmdPulse    <= '0;
            cmdHeld     <= '0;
            unknownCode <= 1'b0;
            lastCode    <= 8'h00;
        end else begin
            cmdPulse    <= pulseNext;
            cmdHeld     <= heldNext;
            unknownCode <= unknownNext;

            if (scan_code_ready && !byteIsPrefix) begin
                lastCode <= scan_code;
            end

            if (scan_code_ready) begin
                case (state)
                    ST_IDLE: begin
                        if (scan_code == SC_BREAK) begin
                            state <= ST_BRK;
                        end else if (scan_code == SC_EXT) begin
                            state <= ST_EXT;
                        end
                    end
                    ST_EXT: begin
                        if (scan_code == SC_BREAK) begin
                            state <= ST_EXT_BRK;
                        end else if (!byteIsPrefix) begin
                            state <= ST_IDLE;
                        end
                    end
                    ST_BRK, ST_EXT_BRK: begin
                        if (!byteIsPrefix) begin
                            state <= ST_IDLE;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end else if (prefExpire) begin
                state <= ST_IDLE;
            end
        end
    end

    assign cmd_pulse    = cmdPulse;
    assign cmd_held     = cmdHeld;
    assign unknown_code = unknownCode;
    assign last_code    = lastCode;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb_ps2_key_decoder
// Self-checking bench for ps2_key_decoder. A behavioural model tracks the
// keyboard in terms of "a prefix is pending / it is a break", a per-key held
// array and timestamps of the last prefix byte and last repeat reload; every
// cycle the four DUT outputs are compared against it. Directed sequences cover
// the documented scenarios, then randomized byte streams with random gaps.
module tb_ps2_key_decoder;

    localparam int unsigned REP = 100;
    localparam int unsigned PTO = 40;

    logic       clk;
    logic       wire_reset;
    logic [7:0] scanCode;
    logic       scanReady;
    logic       enable;
    logic [5:0] cmd_pulse;
    logic [5:0] cmd_held;
    logic       unknown_code;
    logic [7:0] last_code;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    logic [7:0] keyTable [6] = '{8'h6B, 8'h74, 8'h73, 8'h75, 8'h29, 8'h2D};
    logic [5:0] mHeld;
    logic [5:0] expPulse;
    logic       expUnknown;
    logic [7:0] mLast;
    bit         mPrefix;
    bit         mBreak;
    bit         mRepValid;
    longint     cyc;
    longint     mPrefixAt;
    longint     mRepAt;

    ps2_key_decoder #(
        .MOVE_REPEAT_CYCLES(REP),
        .PREFIX_TIMEOUT    (PTO)
    ) dut (
        .topIN_clk_50   (clk),
        .wire_reset     (wire_reset),
        .scan_code      (scanCode),
        .scan_code_ready(scanReady),
        .enable         (enable),
        .cmd_pulse      (cmd_pulse),
        .cmd_held       (cmd_held),
        .unknown_code   (unknown_code),
        .last_code      (last_code)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h",
                     tag, cyc, observed, expected);
        end
    endtask

    task automatic modelReset();
        mHeld      = '0;
        expPulse   = '0;
        expUnknown = 1'b0;
        mLast      = 8'h00;
        mPrefix    = 0;
        mBreak     = 0;
        mRepValid  = 0;
        mPrefixAt  = 0;
        mRepAt     = 0;
    endtask

    // One clock edge of the reference behaviour, using the inputs the DUT saw.
    task automatic modelStep();
        logic [5:0] makeBits;
        logic [5:0] repBits;
        int         idx;
        bit         expired;
        cyc++;
        makeBits   = '0;
        repBits    = '0;
        expUnknown = 1'b0;
        if (scanReady) begin
            if (scanCode == 8'hF0 || scanCode == 8'hE0) begin
                mBreak    = mPrefix ? (mBreak || scanCode == 8'hF0) : (scanCode == 8'hF0);
                mPrefix   = 1;
                mPrefixAt = cyc;
            end else begin
                mLast = scanCode;
                idx   = -1;
                for (int k = 0; k < 6; k++) begin
                    if (keyTable[k] == scanCode) idx = k;
                end
                if (mPrefix && mBreak) begin
                    if (idx >= 0) mHeld[idx] = 1'b0;
                end else if (idx < 0) begin
                    expUnknown = enable;
                end else if (!mHeld[idx]) begin
                    mHeld[idx]    = 1'b1;
                    makeBits[idx] = 1'b1;
                end
                mPrefix = 0;
                mBreak  = 0;
            end
        end else if (mPrefix && (cyc - mPrefixAt == longint'(PTO))) begin
            mPrefix = 0;
            mBreak  = 0;
        end

        if (mHeld[3:0] == 4'b0000) begin
            mRepValid = 0;
        end else if (!enable) begin
            mRepValid = 1;
            mRepAt    = cyc;
        end else begin
            expired = mRepValid && (cyc - mRepAt == longint'(REP));
            if (expired) repBits = {2'b00, mHeld[3:0]};
            if (expired || (makeBits[3:0] != 4'b0000)) begin
                mRepValid = 1;
                mRepAt    = cyc;
            end
        end
        expPulse = enable ? (makeBits | repBits) : 6'b000000;
    endtask

    task automatic compareAll();
        checkOutput("cmd_pulse",    32'(cmd_pulse),    32'(expPulse));
        checkOutput("cmd_held",     32'(cmd_held),     32'(mHeld));
        checkOutput("unknown_code", 32'(unknown_code), 32'(expUnknown));
        checkOutput("last_code",    32'(last_code),    32'(mLast));
    endtask

    // Drive one cycle of input, let the edge happen, then step and compare.
    task automatic applyStimulus(input logic rdy, input logic [7:0] code);
        scanReady = rdy;
        scanCode  = code;
        @(posedge clk);
        modelStep();
        #1;
        compareAll();
        scanReady = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00);
    endtask

    initial begin
        int r;
        int gap;
        logic [7:0] b;

        cyc        = 0;
        wire_reset = 1'b1;
        scanReady  = 1'b0;
        scanCode   = 8'h00;
        enable     = 1'b1;
        modelReset();
        @(posedge clk);
        @(posedge clk);
        #1;
        checkOutput("reset cmd_pulse", 32'(cmd_pulse), 32'h0);
        checkOutput("reset cmd_held", 32'(cmd_held), 32'h0);
        checkOutput("reset unknown", 32'(unknown_code), 32'h0);
        checkOutput("reset last_code", 32'(last_code), 32'h0);
        wire_reset = 1'b0;

        $display("[TB] fire make, typematic, break");
        applyStimulus(1'b1, 8'h29);
        checkOutput("fire make pulse", 32'(cmd_pulse), 32'h10);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'h29);
        checkOutput("fire typematic held", 32'(cmd_held), 32'h10);
        applyStimulus(1'b1, 8'hF0);
        applyStimulus(1'b1, 8'h29);
        checkOutput("fire break held", 32'(cmd_held), 32'h0);

        $display("[TB] extended left with auto-repeat");
        applyStimulus(1'b1, 8'hE0);
        applyStimulus(1'b1, 8'h6B);
        checkOutput("left make pulse", 32'(cmd_pulse), 32'h01);
        idle(int'(REP));
        checkOutput("left repeat 1", 32'(cmd_pulse), 32'h01);
        idle(int'(REP));
        checkOutput("left repeat 2", 32'(cmd_pulse), 32'h01);
        applyStimulus(1'b1, 8'hE0);
        applyStimulus(1'b1, 8'hF0);
        applyStimulus(1'b1, 8'h6B);
        checkOutput("left break held", 32'(cmd_held), 32'h0);
        idle(int'(REP) + 5);

        $display("[TB] prefix timeout");
        applyStimulus(1'b1, 8'hF0);
        idle(int'(PTO));
        applyStimulus(1'b1, 8'h2D);
        checkOutput("reload after timeout", 32'(cmd_pulse), 32'h20);
        applyStimulus(1'b1, 8'hF0);
        idle(int'(PTO) - 1);
        applyStimulus(1'b1, 8'h2D);
        checkOutput("byte beats timeout", 32'(cmd_held), 32'h0);

        $display("[TB] unknown code");
        applyStimulus(1'b1, 8'h1C);
        checkOutput("unknown strobe", 32'(unknown_code), 32'h1);
        checkOutput("unknown last_code", 32'(last_code), 32'h1C);

        $display("[TB] disabled press then enable");
        enable = 1'b0;
        applyStimulus(1'b1, 8'h73);
        checkOutput("disabled no pulse", 32'(cmd_pulse), 32'h0);
        checkOutput("disabled held", 32'(cmd_held), 32'h04);
        enable = 1'b1;
        idle(int'(REP) + 20);
        applyStimulus(1'b1, 8'hF0);
        applyStimulus(1'b1, 8'h73);

        $display("[TB] break coinciding with repeat expiry");
        applyStimulus(1'b1, 8'h6B);
        applyStimulus(1'b1, 8'h73);
        idle(int'(REP) - 2);
        applyStimulus(1'b1, 8'hF0);
        applyStimulus(1'b1, 8'h6B);
        checkOutput("expiry with break", 32'(cmd_pulse), 32'h04);
        applyStimulus(1'b1, 8'hF0);
        applyStimulus(1'b1, 8'h73);

        $display("[TB] reset mid-prefix");
        applyStimulus(1'b1, 8'h74);
        applyStimulus(1'b1, 8'hF0);
        wire_reset = 1'b1;
        #1;
        checkOutput("midreset cmd_pulse", 32'(cmd_pulse), 32'h0);
        checkOutput("midreset cmd_held", 32'(cmd_held), 32'h0);
        checkOutput("midreset unknown", 32'(unknown_code), 32'h0);
        checkOutput("midreset last_code", 32'(last_code), 32'h0);
        modelReset();
        @(posedge clk);
        @(posedge clk);
        #1;
        wire_reset = 1'b0;
        applyStimulus(1'b1, 8'h74);
        checkOutput("right after reset", 32'(cmd_pulse), 32'h02);

        $display("[TB] randomized byte stream");
        for (int n = 0; n < 400; n++) begin
            r = int'($urandom_range(0, 99));
            if (r < 4) enable = 1'b0;
            else if (r < 12) enable = 1'b1;
            r = int'($urandom_range(0, 15));
            if (r < 6) b = keyTable[r];
            else if (r < 9) b = 8'hF0;
            else if (r < 10) b = 8'hE0;
            else if (r < 11) b = 8'h1C;
            else b = 8'($urandom_range(0, 255));
            applyStimulus(1'b1, b);
            r = int'($urandom_range(0, 99));
            if (r < 60) gap = int'($urandom_range(0, 3));
            else if (r < 88) gap = int'($urandom_range(0, 50));
            else gap = int'($urandom_range(30, 130));
            idle(gap);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
